// File: rtl/ssd1306_spi_tx.sv
// rtl/ssd1306_spi_tx.sv - SPI byte serializer and panel-reset sequencer for the SSD1306 OLED
// Optional macro SSD1306_SPI_TX_FIFO_EN adds a FIFO_DEPTH-entry {DC, byte} queue ahead of the shifter.
module ssd1306_spi_tx #(
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int RES_LOW_CLKS      = 16,
   parameter int RES_WAIT_CLKS     = 16,
   parameter int CS_IDLE_CLKS      = 4,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DC,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_D0,
   output logic       o_D1,
   output logic       o_DC,
   output logic       o_CS,
   output logic       o_RES,
   output logic       o_Busy,
   output logic       o_Init_Done
);
   localparam int RES_MAX = (RES_LOW_CLKS > RES_WAIT_CLKS) ? RES_LOW_CLKS : RES_WAIT_CLKS;
   localparam int HW      = $clog2(CLKS_PER_HALF_BIT + 1);
   localparam int RW      = $clog2(RES_MAX + 1);
   localparam int GW      = $clog2(CS_IDLE_CLKS + 1);

   if (CLKS_PER_HALF_BIT < 1 || CS_IDLE_CLKS < 1 || FIFO_DEPTH < 1) begin : g_bad_params
      $error("ssd1306_spi_tx: CLKS_PER_HALF_BIT, CS_IDLE_CLKS and FIFO_DEPTH must be at least 1");
   end

   typedef enum logic [2:0] {S_RES_LOW, S_RES_WAIT, S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t          state, state_next;
   logic [RW-1:0]   res_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [HW-1:0]   half_cnt;
   logic [2:0]      bit_cnt;
   logic            sclk;
   logic [7:0]      shreg;
   logic            dc_reg;
   logic            half_done, gap_done;
   logic            ready, start, start_dc, busy;
   logic [7:0]      start_byte;

   assign half_done = (half_cnt == HW'(CLKS_PER_HALF_BIT - 1));
   assign gap_done  = (gap_cnt == GW'(CS_IDLE_CLKS - 1));

`ifdef SSD1306_SPI_TX_FIFO_EN
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [8:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] fifo_count;
   logic          push;

   assign push = i_TX_DV && ready;

   always_ff @(posedge i_Clk) begin
      if (push) fifo_mem[wr_ptr] <= {i_TX_DC, i_TX_Byte};
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (start) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(start);
      end
   end
`endif

   always_comb begin
      state_next = state;
      start_byte = i_TX_Byte;
      start_dc   = i_TX_DC;
`ifdef SSD1306_SPI_TX_FIFO_EN
      // Queued bytes only leave at the end of a gap so every byte keeps the full CS hold window.
      ready = (state != S_RES_LOW) && (state != S_RES_WAIT) && (fifo_count != CW'(FIFO_DEPTH));
      start = (fifo_count != '0) && ((state == S_IDLE) || (state == S_GAP && gap_done));
      {start_dc, start_byte} = fifo_mem[rd_ptr];
      busy  = (state != S_IDLE) || (fifo_count != '0);
`else
      ready = (state == S_IDLE) || (state == S_GAP);
      start = i_TX_DV && ready;
      busy  = (state != S_IDLE);
`endif
      case (state)
         S_RES_LOW:  if (res_cnt == RW'(RES_LOW_CLKS - 1)) state_next = S_RES_WAIT;
         S_RES_WAIT: if (res_cnt == RW'(RES_WAIT_CLKS - 1)) state_next = S_IDLE;
         S_IDLE:     if (start) state_next = S_SHIFT;
         S_SHIFT:    if (half_done && sclk && bit_cnt == 3'd7) state_next = S_GAP;
         S_GAP: begin
            if (start) state_next = S_SHIFT;
            else if (gap_done) state_next = S_IDLE;
         end
         default:    state_next = S_RES_LOW;
      endcase

      o_TX_Ready  = ready;
      o_Busy      = busy;
      o_D0        = sclk;
      o_D1        = shreg[7];
      o_DC        = dc_reg;
      o_CS        = !((state == S_SHIFT) || (state == S_GAP));
      o_RES       = (state != S_RES_LOW);
      o_Init_Done = (state != S_RES_LOW) && (state != S_RES_WAIT);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state    <= S_RES_LOW;
         res_cnt  <= '0;
         gap_cnt  <= '0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         sclk     <= 1'b0;
         shreg    <= '0;
         dc_reg   <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next != state) res_cnt <= '0;
         else if (state == S_RES_LOW || state == S_RES_WAIT) res_cnt <= res_cnt + RW'(1);
         if (state == S_GAP && state_next == S_GAP) gap_cnt <= gap_cnt + GW'(1);
         else gap_cnt <= '0;
         if (start) begin
            shreg    <= start_byte;
            dc_reg   <= start_dc;
            half_cnt <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
         end else if (state == S_SHIFT) begin
            if (half_done) begin
               half_cnt <= '0;
               sclk     <= ~sclk;
               // Advance MOSI only as a high half ends; the last bit stays on D1 afterwards.
               if (sclk) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt != 3'd7) shreg <= {shreg[6:0], 1'b0};
               end
            end else begin
               half_cnt <= half_cnt + HW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// tb/tb_ssd1306_spi_tx.sv - randomized self-checking bench for ssd1306_spi_tx against a timeline model
// Build with SSD1306_SPI_TX_FIFO_EN to model and exercise the input queue as well.
module tb_ssd1306_spi_tx;
   localparam int H = 1, RL = 4, RW = 4, G = 2, DEPTH = 4;
   localparam int SHIFT_LEN = 16 * H;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_byte = 8'h00;
   logic       tx_dc = 1'b0, tx_dv = 1'b0;
   logic       d0, d1, dc, cs, res, rdy, busy, init;

   always #5 clk = ~clk;

   ssd1306_spi_tx #(
      .CLKS_PER_HALF_BIT(H), .RES_LOW_CLKS(RL), .RES_WAIT_CLKS(RW),
      .CS_IDLE_CLKS(G), .FIFO_DEPTH(DEPTH)
   ) dut (
      .i_Clk(clk), .i_Reset(rst), .i_TX_Byte(tx_byte), .i_TX_DC(tx_dc), .i_TX_DV(tx_dv),
      .o_TX_Ready(rdy), .o_D0(d0), .o_D1(d1), .o_DC(dc), .o_CS(cs), .o_RES(res),
      .o_Busy(busy), .o_Init_Done(init)
   );

   int         checks = 0, failures = 0;
   int         cyc = 0, t_start = -1;
   bit         armed = 1'b0, accepted = 1'b0;
   logic [7:0] m_byte = 8'h00;
   logic       m_dc = 1'b0;
   logic [8:0] q[$];
   bit         rise_q[$], rise_dc[$];
   logic       prev_d0 = 1'b0;
   int         cs_run = 0, last_run = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (model cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Phase from elapsed time: 0 reset sequence, 1 idle, 2 shifting, 3 CS hold gap.
   function automatic int phase_of(output int k);
      k = cyc - (t_start + 1);
      if (cyc < RL + RW) return 0;
      if (t_start < 0 || k >= SHIFT_LEN + G) return 1;
      if (k < SHIFT_LEN) return 2;
      return 3;
   endfunction

   function automatic logic [63:0] rise_word(input bit use_dc);
      logic [63:0] r = '0;
      for (int i = 0; i < rise_q.size(); i++) r = {r[62:0], use_dc ? rise_dc[i] : rise_q[i]};
      return r;
   endfunction

   task automatic tick();
      int   k, ph;
      logic e_rdy, e_busy;
      ph = phase_of(k);
`ifdef SSD1306_SPI_TX_FIFO_EN
      e_rdy  = (ph != 0) && (q.size() < DEPTH);
      e_busy = (ph != 1) || (q.size() != 0);
`else
      e_rdy  = (ph == 1) || (ph == 3);
      e_busy = (ph != 1);
`endif
      if (armed) begin
         chk("RES", res, cyc >= RL);
         chk("Init_Done", init, ph != 0);
         chk("TX_Ready", rdy, e_rdy);
         chk("Busy", busy, e_busy);
         chk("CS", cs, !(ph == 2 || ph == 3));
         chk("D0", d0, (ph == 2) ? (k / H) % 2 : 0);
         chk("D1", d1, (ph == 2) ? m_byte[7 - k / (2 * H)] : m_byte[0]);
         chk("DC", dc, m_dc);
         if (d0 && !prev_d0) begin
            rise_q.push_back(d1);
            rise_dc.push_back(dc);
         end
         if (!cs) cs_run++;
         else if (cs_run != 0) begin
            last_run = cs_run;
            cs_run   = 0;
         end
         prev_d0 = d0;
      end
      accepted = 1'b0;
      if (rst) begin
         cyc = 0; t_start = -1; m_byte = 8'h00; m_dc = 1'b0;
         q.delete(); armed = 1'b1; cs_run = 0;
      end else begin
`ifdef SSD1306_SPI_TX_FIFO_EN
         if (q.size() != 0 && (ph == 1 || (ph == 3 && k == SHIFT_LEN + G - 1))) begin
            {m_dc, m_byte} = q.pop_front();
            t_start = cyc;
         end
         if (tx_dv && e_rdy) begin
            q.push_back({tx_dc, tx_byte});
            accepted = 1'b1;
         end
`else
         if (tx_dv && e_rdy) begin
            m_byte = tx_byte; m_dc = tx_dc; t_start = cyc; accepted = 1'b1;
         end
`endif
         cyc++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      tx_dv = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [7:0] b, input logic d);
      int n = 0;
      tx_byte = b; tx_dc = d; tx_dv = 1'b1;
      tick();
      while (!accepted && n < 200) begin
         tick();
         n++;
      end
      if (!accepted) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: byte %0h still not accepted after %0d cycles, required acceptance", b, n);
      end
      tx_dv = 1'b0;
   endtask

   task automatic clear_rises();
      rise_q.delete();
      rise_dc.delete();
   endtask

   initial begin
      @(negedge clk);
      tick();
      chk("reset_CS", cs, 1);
      chk("reset_D0", d0, 0);
      chk("reset_D1", d1, 0);
      chk("reset_DC", dc, 0);
      chk("reset_RES", res, 0);
      chk("reset_Ready", rdy, 0);
      chk("reset_Busy", busy, 1);
      chk("reset_Init", init, 0);
      tick();
      rst = 1'b0;
      tick(); tick();
      tx_dv = 1'b1; tx_byte = 8'h81;
      tick();
      tx_dv = 1'b0;
      chk("cycle3_RES", res, 0);
      chk("cycle3_CS", cs, 1);
      tick();
      chk("cycle4_RES", res, 1);
      tick(); tick(); tick();
      chk("cycle7_Init", init, 0);
      chk("cycle7_Ready", rdy, 0);
      tick();
      chk("cycle8_Init", init, 1);
      chk("cycle8_Ready", rdy, 1);
      chk("early_dv_no_rises", rise_q.size(), 0);
      idle(3);

      clear_rises();
      send(8'hA5, 1'b0);
      idle(25);
      chk("a5_rise_count", rise_q.size(), 8);
      chk("a5_bits", rise_word(0), 64'hA5);
      chk("a5_dc", rise_word(1), 64'h00);
      chk("a5_cs_low_len", last_run, 18);

      clear_rises();
      send(8'hAE, 1'b0);
      send(8'hFF, 1'b1);
      idle(25);
      chk("pair_rise_count", rise_q.size(), 16);
      chk("pair_bits", rise_word(0), 64'hAEFF);
      chk("pair_dc", rise_word(1), 64'h00FF);
      chk("pair_cs_low_len", last_run, 35);

      clear_rises();
      send(8'h3C, 1'b0);
      idle(7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_CS", cs, 1);
      chk("midrst_D0", d0, 0);
      chk("midrst_RES", res, 0);
      chk("midrst_Init", init, 0);
      idle(RL + RW + 20);
      chk("midrst_partial_rises", rise_q.size(), 4);

      for (int i = 0; i < 60; i++) begin
         send(8'($urandom), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 22));
         if ($urandom_range(0, 11) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
      end
      idle(40);

`ifdef SSD1306_SPI_TX_FIFO_EN
      clear_rises();
      send(8'h11, 1'b0);
      send(8'h22, 1'b1);
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      send(8'h55, 1'b0);
      chk("fifo_full_ready", rdy, 0);
      chk("fifo_full_busy", busy, 1);
      send(8'h66, 1'b1);
      idle(150);
      chk("fifo_rise_count", rise_q.size(), 48);
      chk("fifo_bits", rise_word(0), 64'h112233445566);
      chk("fifo_cs_low_len", last_run, 108);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before the summary line");
      $fatal(1, "watchdog");
   end
endmodule
